pwm_dualport_rams: RTL and testbench
====================================

PWM_DUALPORT_RAMS -- requirements
Module: pwm_dualport_rams

Interface
REQ-001 Parameter: MEM_INIT_ZERO, default 1, meaning: 1 = both arrays hold all-zero contents at time 0 (configuration/simulation start); 0 = contents X until written.
REQ-002 Clock/reset: reset reset, asynchronous, active-high; clock pwm_clk.
REQ-003 reset  in  1  asynchronous active-high; clears read-data registers only.
REQ-004 pwm_clk  in  1  read-side clock; all read ports are synchronous to it.
REQ-005 cpu_clk  in  1  write-side clock, asynchronous to pwm_clk.
REQ-006 pix_we  in  1  pixmap byte write enable (cpu_clk).
REQ-007 pix_waddr  in  10  pixmap byte address, 0x000-0x3FF.
REQ-008 pix_wdata  in  8  pixmap write byte.
REQ-009 pix_raddr  in  7  pixmap 64-bit line address, 0-127.
REQ-010 pix_rdata  out  64  registered pixmap line.
REQ-011 tab_we  in  1  table word write enable (cpu_clk).
REQ-012 tab_waddr  in  8  table write address.
REQ-013 tab_wdata  in  16  table write word.
REQ-014 tab_raddr  in  8  table read address.
REQ-015 tab_rdata  out  16  registered table word.

Function
REQ-016 Pixmap: 1024 x 8 storage, 8-bit write port on cpu_clk, 64-bit read port on pwm_clk; one shared array, same bits seen by both ports.
REQ-017 Pixmap write: on rising cpu_clk with pix_we=1, byte at pix_waddr <= pix_wdata; pix_we=0 -> no change.
REQ-018 Pixmap read mapping: line L = bytes 8L..8L+7; byte 8L+j appears on pix_rdata[8j+7:8j], j=0..7 (lowest address in LSB lane).
REQ-019 Pixmap read: every rising pwm_clk (reset low) registers line pix_raddr into pix_rdata; latency exactly 1 pwm_clk; no read enable; back-to-back addresses each cycle supported.
REQ-020 Table: 256 x 16 storage; on rising cpu_clk with tab_we=1, word tab_waddr <= tab_wdata.
REQ-021 Table read: every rising pwm_clk (reset low) registers word tab_raddr into tab_rdata; latency 1 pwm_clk.
REQ-022 Addresses full-width decoded, no aliasing; 0x3FF/127/0xFF are valid last entries, no wrap beyond.
REQ-023 Writes touch only the addressed byte/word; other lanes of the same pixmap line unchanged.
REQ-024 Cross-domain visibility: a write committed at a cpu_clk edge is returned by any pwm_clk read sampled at least one full pwm_clk period later.
REQ-025 Collision (read of a location on a pwm_clk edge within one pwm_clk period of its write): returns entirely old or entirely new byte/word, never a mix or X; benches do not check value in this window.
REQ-026 Simultaneous pix_we and tab_we: both writes independent, both commit.
REQ-027 No read-side write path; no write-side read path.

Reset
REQ-028 reset=1 forces pix_rdata=0 and tab_rdata=0 immediately (asynchronous), held while reset=1.
REQ-029 reset does not alter array contents and does not block cpu_clk writes; writes during reset commit normally.
REQ-030 After reset deasserts, first rising pwm_clk loads read data per REQ-019/021.
REQ-031 Arrays never cleared by logic; initial contents per MEM_INIT_ZERO only.

Verification
REQ-032 Write 0x01..0x08 to pixmap 0x008..0x00F, pix_raddr=1 -> pix_rdata=0x0807060504030201 one pwm_clk later.
REQ-033 Write table 0xFF=0xBEEF, 0x00=0x1234; tab_raddr 0xFF then 0x00 on consecutive cycles -> tab_rdata 0xBEEF then 0x1234, each 1-cycle latency.
REQ-034 With nonzero outputs, assert reset between clock edges -> both outputs 0 without a clock edge; release, re-read -> prior contents returned unchanged.
REQ-035 Write pixmap 0x3FF=0xAA, then 0x3F8=0x55 -> line 127 reads 0xAA000000000000 55 (bits[63:56]=0xAA, [7:0]=0x55, others unchanged); tab_we=0 write cycle -> table unchanged.
REQ-036 cpu_clk 50 MHz, pwm_clk 33 MHz, random writes to both arrays with continuous reads -> outside collision windows, every read matches a reference model.
REQ-037 MEM_INIT_ZERO=1, no writes, read line 0 and table 0 -> both 0.

Source files
------------

// File: rtl/pwm_dualport_rams.sv
// Dual-clock storage for the PWM engine: a byte-written / line-read pixmap and a
// word-wide lookup table, both written from cpu_clk and read from pwm_clk.
`timescale 1ns/1ps
module pwm_dualport_rams #(
  parameter bit MEM_INIT_ZERO = 1'b1
) (
  input  logic        reset,
  input  logic        pwm_clk,
  input  logic        cpu_clk,
  input  logic        pix_we,
  input  logic [9:0]  pix_waddr,
  input  logic [7:0]  pix_wdata,
  input  logic [6:0]  pix_raddr,
  output logic [63:0] pix_rdata,
  input  logic        tab_we,
  input  logic [7:0]  tab_waddr,
  input  logic [15:0] tab_wdata,
  input  logic [7:0]  tab_raddr,
  output logic [15:0] tab_rdata
);

  // Contents start either cleared or undefined; nothing in the logic ever clears them.
  logic [7:0]  pix_mem [1024] = '{default: (MEM_INIT_ZERO ? 8'h00 : 8'hxx)};
  logic [15:0] tab_mem [256]  = '{default: (MEM_INIT_ZERO ? 16'h0000 : 16'hxxxx)};

  logic [63:0] pix_line;

  // cpu_clk write side: ignores reset so configuration can load while the engine is held.
  always_ff @(posedge cpu_clk) begin
    if (pix_we) pix_mem[pix_waddr] <= pix_wdata;
    if (tab_we) tab_mem[tab_waddr] <= tab_wdata;
  end

  // Lowest byte address of a line lands in the least significant lane.
  always_comb begin
    pix_line = '0;
    for (int j = 0; j < 8; j++) begin
      pix_line[8*j +: 8] = pix_mem[{pix_raddr, 3'(j)}];
    end
  end

  // pwm_clk read side: one-cycle registered reads, outputs forced low during reset.
  always_ff @(posedge pwm_clk or posedge reset) begin
    if (reset) begin
      pix_rdata <= '0;
      tab_rdata <= '0;
    end else begin
      pix_rdata <= pix_line;
      tab_rdata <= tab_mem[tab_raddr];
    end
  end

endmodule

// File: tb/tb_pwm_dualport_rams.sv
// Directed and randomized checks of the dual-clock pixmap/table storage.
`timescale 1ns/1ps
module tb_pwm_dualport_rams;

  logic        reset;
  logic        pwm_clk;
  logic        cpu_clk;
  logic        pix_we;
  logic [9:0]  pix_waddr;
  logic [7:0]  pix_wdata;
  logic [6:0]  pix_raddr;
  logic [63:0] pix_rdata;
  logic        tab_we;
  logic [7:0]  tab_waddr;
  logic [15:0] tab_wdata;
  logic [7:0]  tab_raddr;
  logic [15:0] tab_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  model_pix [1024];
  logic [15:0] model_tab [256];

  typedef struct {
    bit          is_tab;
    logic [9:0]  addr;
    logic [63:0] expv;
    string       name;
  } vec_t;

  vec_t vecs [10];

  pwm_dualport_rams #(.MEM_INIT_ZERO(1'b1)) dut (
    .reset     (reset),
    .pwm_clk   (pwm_clk),
    .cpu_clk   (cpu_clk),
    .pix_we    (pix_we),
    .pix_waddr (pix_waddr),
    .pix_wdata (pix_wdata),
    .pix_raddr (pix_raddr),
    .pix_rdata (pix_rdata),
    .tab_we    (tab_we),
    .tab_waddr (tab_waddr),
    .tab_wdata (tab_wdata),
    .tab_raddr (tab_raddr),
    .tab_rdata (tab_rdata)
  );

  initial cpu_clk = 1'b0;
  always #10 cpu_clk = ~cpu_clk;   // 50 MHz
  initial pwm_clk = 1'b0;
  always #15 pwm_clk = ~pwm_clk;   // ~33 MHz

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, req);
    end
  endtask

  task automatic cpu_write(input bit pw, input logic [9:0] pa, input logic [7:0] pd,
                           input bit tw, input logic [7:0] ta, input logic [15:0] td);
    @(negedge cpu_clk);
    pix_we = pw; pix_waddr = pa; pix_wdata = pd;
    tab_we = tw; tab_waddr = ta; tab_wdata = td;
    @(posedge cpu_clk);
    #1;
    pix_we = 1'b0;
    tab_we = 1'b0;
    if (pw) model_pix[pa] = pd;
    if (tw) model_tab[ta] = td;
  endtask

  // Set read addresses mid-cycle, then sample just after the next pwm edge.
  task automatic pwm_read(input logic [6:0] pl, input logic [7:0] ta);
    @(negedge pwm_clk);
    pix_raddr = pl;
    tab_raddr = ta;
    @(posedge pwm_clk);
    #1;
  endtask

  function automatic logic [63:0] model_line(input logic [6:0] l);
    logic [63:0] v;
    for (int j = 0; j < 8; j++) v[8*j +: 8] = model_pix[{l, 3'(j)}];
    return v;
  endfunction

  task automatic settle();
    repeat (3) @(posedge pwm_clk);
  endtask

  initial begin
    reset = 1'b1;
    pix_we = 1'b0; pix_waddr = '0; pix_wdata = '0; pix_raddr = '0;
    tab_we = 1'b0; tab_waddr = '0; tab_wdata = '0; tab_raddr = '0;
    for (int i = 0; i < 1024; i++) model_pix[i] = 8'h00;
    for (int i = 0; i < 256; i++) model_tab[i] = 16'h0000;

    // Reset state
    repeat (2) @(posedge pwm_clk);
    #1;
    check("reset_pix", pix_rdata, 64'h0);
    check("reset_tab", {48'h0, tab_rdata}, 64'h0);
    @(negedge pwm_clk);
    reset = 1'b0;

    // Zero-initialized contents before any write
    pwm_read(7'd0, 8'h00);
    check("init_pix_line0", pix_rdata, 64'h0);
    check("init_tab0", {48'h0, tab_rdata}, 64'h0);

    // Directed writes
    for (int i = 0; i < 8; i++) cpu_write(1'b1, 10'h008 + 10'(i), 8'(i + 1), 1'b0, 8'h00, 16'h0);
    cpu_write(1'b0, 10'h000, 8'h00, 1'b1, 8'hFF, 16'hBEEF);
    cpu_write(1'b0, 10'h000, 8'h00, 1'b1, 8'h00, 16'h1234);
    cpu_write(1'b1, 10'h3FF, 8'hAA, 1'b0, 8'h00, 16'h0);
    cpu_write(1'b1, 10'h3F8, 8'h55, 1'b0, 8'h00, 16'h0);
    cpu_write(1'b0, 10'h000, 8'h00, 1'b0, 8'h00, 16'hFFFF);   // tab_we low: no change
    cpu_write(1'b1, 10'h100, 8'h5A, 1'b1, 8'h80, 16'hC3C3);   // simultaneous writes
    settle();

    vecs[0] = '{1'b0, 10'd1,   64'h0807060504030201, "pix_line1"};
    vecs[1] = '{1'b0, 10'd127, 64'hAA00000000000055, "pix_line127"};
    vecs[2] = '{1'b0, 10'd0,   64'h0,                "pix_line0"};
    vecs[3] = '{1'b0, 10'd32,  64'h000000000000005A, "pix_line32"};
    vecs[4] = '{1'b0, 10'd126, 64'h0,                "pix_line126"};
    vecs[5] = '{1'b1, 10'hFF,  64'hBEEF,             "tab_ff"};
    vecs[6] = '{1'b1, 10'h00,  64'h1234,             "tab_00_we0"};
    vecs[7] = '{1'b1, 10'h80,  64'hC3C3,             "tab_80"};
    vecs[8] = '{1'b1, 10'h01,  64'h0,                "tab_01"};
    vecs[9] = '{1'b1, 10'hFE,  64'h0,                "tab_fe"};

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_tab) begin
        pwm_read(7'd0, vecs[i].addr[7:0]);
        check(vecs[i].name, {48'h0, tab_rdata}, vecs[i].expv);
      end else begin
        pwm_read(vecs[i].addr[6:0], 8'h00);
        check(vecs[i].name, pix_rdata, vecs[i].expv);
      end
    end

    // Back-to-back reads on consecutive pwm cycles
    pwm_read(7'd1, 8'hFF);
    check("b2b_tab_ff", {48'h0, tab_rdata}, 64'hBEEF);
    pix_raddr = 7'd127;
    tab_raddr = 8'h00;
    @(posedge pwm_clk);
    #1;
    check("b2b_tab_00", {48'h0, tab_rdata}, 64'h1234);
    check("b2b_pix_127", pix_rdata, 64'hAA00000000000055);

    // Asynchronous reset between edges, writes during reset still commit
    pwm_read(7'd1, 8'h00);
    #4;
    reset = 1'b1;
    #1;
    check("async_rst_pix", pix_rdata, 64'h0);
    check("async_rst_tab", {48'h0, tab_rdata}, 64'h0);
    cpu_write(1'b0, 10'h000, 8'h00, 1'b1, 8'h10, 16'h7777);
    @(posedge pwm_clk);
    #1;
    check("held_rst_pix", pix_rdata, 64'h0);
    check("held_rst_tab", {48'h0, tab_rdata}, 64'h0);
    settle();
    @(negedge pwm_clk);
    reset = 1'b0;
    @(posedge pwm_clk);
    #1;
    check("post_rst_pix", pix_rdata, 64'h0807060504030201);
    check("post_rst_tab", {48'h0, tab_rdata}, 64'h1234);
    pwm_read(7'd1, 8'h10);
    check("rst_write_tab10", {48'h0, tab_rdata}, 64'h7777);

    // Random writes to both arrays, reads compared against the model
    for (int i = 0; i < 40; i++) begin
      logic [9:0]  pa;
      logic [7:0]  ta;
      logic [6:0]  rl;
      logic [7:0]  rt;
      pa = 10'($urandom_range(0, 1023));
      ta = 8'($urandom_range(0, 255));
      cpu_write($urandom_range(0, 1) == 1, pa, 8'($urandom), $urandom_range(0, 1) == 1, ta, 16'($urandom));
      settle();
      pwm_read(pa[9:3], ta);
      check("rnd_pix_written", pix_rdata, model_line(pa[9:3]));
      check("rnd_tab_written", {48'h0, tab_rdata}, {48'h0, model_tab[ta]});
      rl = 7'($urandom_range(0, 127));
      rt = 8'($urandom_range(0, 255));
      pwm_read(rl, rt);
      check("rnd_pix_any", pix_rdata, model_line(rl));
      check("rnd_tab_any", {48'h0, tab_rdata}, {48'h0, model_tab[rt]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
